// File: rtl/mux4a1_rr_scheduler_pkg.sv
// Shared definitions for the 4-lane round-robin scheduler.
//   NUM_LANES     number of input byte lanes
//   LANE_IDX_W    width of a lane index (sel_out, last_grant)
//   DEFAULT_WIDTH default data width of every lane
//   rr_pick()     first non-empty lane after 'last', wrapping back to 'last'
package mux4a1_rr_scheduler_pkg;

    localparam int NUM_LANES     = 4;
    localparam int LANE_IDX_W    = 2;
    localparam int DEFAULT_WIDTH = 8;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Scan order is last+1, last+2, last+3, last+0 (mod NUM_LANES); the
    // previous owner is considered last so every other lane gets a turn first.
    function automatic lane_idx_t rr_pick(input logic [NUM_LANES-1:0] nonempty,
                                          input lane_idx_t            last);
        lane_idx_t pick;
        lane_idx_t cand;
        logic      found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = last + lane_idx_t'(k);
            if (!found && nonempty[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4a1_rr_scheduler_lane_fifo.sv
// lane_fifo: small synchronous FIFO buffering one input lane.
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   push        write data_in (ignored when full)
//   data_in     WIDTH-bit write data
//   pop         drop the head entry (ignored when empty)
//   head        current head entry, valid while count != 0
//   count       occupancy, 0..DEPTH
// Push and pop in the same cycle leave count unchanged. DEPTH must be a
// power of two so the pointers wrap naturally.
module lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != DEPTH_C);
    assign do_pop  = pop && (cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after it was written,
    // so clearing it would only cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/mux4a1_rr_scheduler.sv
// mux4a1_rr_scheduler: buffers four valid/ready byte lanes and schedules them
// round-robin, with bounded bursts, onto one registered valid/ready output.
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   valid0..3/data_in0..3 lane i offers a beat
//   ready0..3            lane i FIFO has room (forced low during reset)
//   valid_out/data_out   scheduled beat; sel_out names its source lane
//   ready_out            downstream takes the beat when valid_out && ready_out
// ready_i depends only on FIFO occupancy, never on ready_out.
module mux4a1_rr_scheduler
    import mux4a1_rr_scheduler_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid0,
    input  logic                  valid1,
    input  logic                  valid2,
    input  logic                  valid3,
    input  logic [WIDTH-1:0]      data_in0,
    input  logic [WIDTH-1:0]      data_in1,
    input  logic [WIDTH-1:0]      data_in2,
    input  logic [WIDTH-1:0]      data_in3,
    output logic                  ready0,
    output logic                  ready1,
    output logic                  ready2,
    output logic                  ready3,
    output logic                  valid_out,
    output logic [WIDTH-1:0]      data_out,
    output logic [LANE_IDX_W-1:0] sel_out,
    input  logic                  ready_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [BW-1:0] MAX_BURST_C = BW'(MAX_BURST);

    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] lane_ready;
    logic [NUM_LANES-1:0] lane_push;
    logic [NUM_LANES-1:0] lane_pop;
    logic [NUM_LANES-1:0] lane_nonempty;
    logic [WIDTH-1:0]     lane_data  [NUM_LANES];
    logic [WIDTH-1:0]     lane_head  [NUM_LANES];
    logic [CW-1:0]        lane_count [NUM_LANES];

    lane_idx_t     last_grant;
    lane_idx_t     grant;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_next;
    logic          load;
    logic          regrant;
    logic          grant_empties;

    assign lane_valid   = {valid3, valid2, valid1, valid0};
    assign lane_data[0] = data_in0;
    assign lane_data[1] = data_in1;
    assign lane_data[2] = data_in2;
    assign lane_data[3] = data_in3;
    assign {ready3, ready2, ready1, ready0} = lane_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_ready[i]    = (lane_count[i] < DEPTH_C) && !reset;
        assign lane_push[i]     = lane_valid[i] && lane_ready[i];
        assign lane_nonempty[i] = (lane_count[i] != '0);

        lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push    (lane_push[i]),
            .data_in (lane_data[i]),
            .pop     (lane_pop[i]),
            .head    (lane_head[i]),
            .count   (lane_count[i])
        );
    end

    // burst_cnt == 0 means no lane currently holds the grant (after reset, or
    // after the granted lane drained), so the next load always rotates.
    // NOTE: every signal written here gets a value on every path (defaults
    // first), otherwise synthesis would infer latches.
    always_comb begin
        lane_pop      = '0;
        load          = (!valid_out || ready_out) && (lane_nonempty != '0);
        regrant       = (burst_cnt != '0) && (burst_cnt < MAX_BURST_C)
                        && lane_nonempty[last_grant];
        grant         = regrant ? last_grant : rr_pick(lane_nonempty, last_grant);
        grant_empties = (lane_count[grant] == CW'(1)) && !lane_push[grant];
        burst_next    = regrant ? burst_cnt + BW'(1) : BW'(1);
        if (grant_empties) burst_next = '0;
        if (load) lane_pop[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            sel_out    <= '0;
            last_grant <= lane_idx_t'(NUM_LANES - 1);
            burst_cnt  <= '0;
        end else if (load) begin
            valid_out  <= 1'b1;
            data_out   <= lane_head[grant];
            sel_out    <= grant;
            last_grant <= grant;
            burst_cnt  <= burst_next;
        end else if (ready_out) begin
            valid_out  <= 1'b0;
        end
    end

endmodule
